// File: rtl/typed_word_deser_if.sv
// Link-side and consumer-side handshake bundle for the typed-record deserializer.
// A transfer happens on a rising clk edge exactly when valid && ready; the sender holds data stable while valid && !ready.
interface typed_word_deser_if #(
  parameter int DATA_W = 8,
  parameter int W      = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [2:0]        out_mode;
  logic              out_mode_err;

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_mode_err
  );

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_mode_err
  );
endinterface

// File: rtl/typed_word_deser.sv
// Reassembles sof-framed link beats (MSB beat first) into one record word and
// exposes its 3-bit mode field with an illegal-mode flag.
module typed_word_deser #(
  parameter int DATA_W   = 8,
  parameter int NB_BEATS = 4,
  parameter int MODE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  typed_word_deser_if.slave    bus,
  output logic                 err_drop,
  output logic                 err_resync,
  output logic [15:0]          frame_cnt,
  output logic [1:0]           dbg_state
);
  localparam int W     = NB_BEATS * DATA_W;
  localparam int CNT_W = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     data_q;
  logic             out_valid_q;
  logic [W-1:0]     slot0_word;
  logic [W-1:0]     merged_word;
  logic             last_slot;

  // slot0_word starts a fresh record; merged_word drops the beat into slot cnt.
  always_comb begin
    slot0_word = '0;
    slot0_word[W-1 -: DATA_W] = bus.in_data;
    merged_word = data_q;
    for (int i = 0; i < NB_BEATS; i++) begin
      if (i == int'(cnt)) merged_word[W-1-i*DATA_W -: DATA_W] = bus.in_data;
    end
    last_slot = (int'(cnt) == NB_BEATS - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      err_drop    <= 1'b0;
      err_resync  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      err_drop   <= 1'b0;
      err_resync <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_sof) begin
              data_q <= slot0_word;
              if (NB_BEATS == 1) begin
                state       <= FULL;
                out_valid_q <= 1'b1;
                cnt         <= '0;
              end else begin
                state <= COLLECT;
                cnt   <= CNT_W'(1);
              end
            end else begin
              err_drop <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.in_valid) begin
            if (bus.in_sof) begin
              // Restart: the partial record is abandoned, not delivered.
              data_q     <= slot0_word;
              cnt        <= CNT_W'(1);
              err_resync <= 1'b1;
            end else begin
              data_q <= merged_word;
              if (last_slot) begin
                state       <= FULL;
                out_valid_q <= 1'b1;
                cnt         <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        FULL: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            cnt         <= '0;
            frame_cnt   <= frame_cnt + 16'd1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

  // in_ready is a pure state decode so out_ready never reaches it.
  assign bus.in_ready     = (state != FULL);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = data_q;
  assign bus.out_mode     = data_q[W-1 -: 3];
  assign bus.out_mode_err = out_valid_q && (bus.out_mode > 3'(MODE_MAX));
  assign dbg_state        = state;
endmodule

// File: doc/typed_word_deser.md
Name: typed_word_deser

Overview:
- Receive side of the typed-record byte link. Reassembles a framed byte stream into one packed record word of NB_BEATS*DATA_W bits.
- Extracts the 3-bit mode field from the word's MSBs and flags illegal modes.
- Sits between the byte-link receiver and the record consumers. It mirrors the serializer that packs a mode+subtype record onto the link, MSB byte first.

Parameters:
- DATA_W, 8, width of one link beat in bits.
- NB_BEATS, 4, beats per record; record width W = NB_BEATS*DATA_W (min 1).
- MODE_MAX, 3, highest legal mode value (the enum covers 0..3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  beat payload.
- in_sof  in  1  beat is first of a record.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts record.
- out_data  out  W  assembled record; first beat in bits [W-1 -: DATA_W].
- out_mode  out  3  out_data[W-1 -: 3].
- out_mode_err  out  1  out_valid && (out_mode > MODE_MAX).
- err_drop  out  1  one-cycle pulse: beat without sof dropped while IDLE.
- err_resync  out  1  one-cycle pulse: sof seen mid-record, partial discarded.
- frame_cnt  out  16  count of records handed off (out handshakes).

Behaviour:
- Reset (clk edge with rst=1): state IDLE, beat counter 0, out_valid 0, out_data 0, err_drop 0, err_resync 0, frame_cnt 0.
  - Reset mid-record discards the partial record.
  - Reset while FULL drops the held record without counting it.
- State machine IDLE -> COLLECT -> FULL.
- IDLE:
  - in_ready=1.
  - Accepted beat with sof: store at slot 0, cnt=1, go COLLECT. If NB_BEATS==1, go FULL directly.
  - Accepted beat without sof: discard, pulse err_drop next cycle, stay IDLE.
- COLLECT:
  - in_ready=1.
  - Accepted beat without sof: store at slot cnt (bits [W-1-cnt*DATA_W -: DATA_W]), cnt++.
  - When the beat stored at slot NB_BEATS-1 is accepted, go FULL.
  - Accepted beat with sof: clear partial data, store beat at slot 0, cnt=1, stay COLLECT, pulse err_resync.
  - No beat accepted: hold; no timeout.
- FULL:
  - in_ready=0; out_valid=1.
  - out_data and out_mode stay stable until out_valid && out_ready.
  - On handshake: out_valid drops next cycle, state IDLE, cnt=0, frame_cnt++.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: one record per NB_BEATS+1 cycles when out_ready is held high.
- out_mode_err is combinational from the held word. It is 0 whenever out_valid=0. The record is still delivered when the flag is set.
- frame_cnt wraps 0xFFFF -> 0x0000 with no flag.
- err_drop and err_resync are registered, exactly one cycle per event, never both in the same cycle.
- in_ready depends only on state (no combinational path from out_ready).

Test Plan:
- Basic record: DATA_W=8, NB_BEATS=4, beats 0x41(sof),0x22,0x33,0x44 back-to-back, out_ready=1 -> out_valid exactly 1 cycle after the 4th beat; out_data=0x41223344, out_mode=2, out_mode_err=0, frame_cnt=1.
- Backpressure: same record with out_ready=0 for 5 cycles -> out_valid held, out_data stable, in_ready=0 throughout; a sof beat offered meanwhile is not accepted; after out_ready=1, frame_cnt=1 and the pending beat is then accepted in IDLE.
- Illegal mode: beats 0xE0(sof),0,0,1 -> out_mode=7, out_mode_err=1 while out_valid; record still delivered, frame_cnt increments.
- Resync/drop: 0x11 without sof in IDLE -> err_drop pulse, nothing stored. Then 0x10(sof),0x20,0x30(sof),0x31,0x32,0x33 -> one err_resync pulse; only 0x30313233 is delivered.
- Reset mid-record: 2 beats accepted, rst=1 for 1 cycle, then a full record 0x01020304 -> output 0x01020304 only, frame_cnt=1, no error pulses.
- Wrap: force 65536 handshakes (or NB_BEATS=1 streaming) -> frame_cnt goes 0xFFFF -> 0x0000.
